// File: rtl/fei4_rx_arbiter.sv
// Round-robin read scheduler merging up to 16 FE-I4 receiver record FIFOs into one
// channel-tagged 32-bit stream, with a per-grant burst limit for fairness.
module fei4_rx_arbiter #(
  parameter int unsigned N_CH      = 4,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST_N,
  input  logic [N_CH-1:0]      CH_EN,
  input  logic [N_CH-1:0]      FIFO_EMPTY,
  input  logic [24*N_CH-1:0]   FIFO_DATA,
  output logic [N_CH-1:0]      FIFO_READ,
  output logic [31:0]          OUT_DATA,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic [3:0]           GRANT_CH,
  output logic                 BUSY,
  output logic [31:0]          WORD_CNT
);

  localparam int unsigned CH_W    = 4;
  localparam int unsigned DATA_W  = 24;
  localparam int unsigned CNT_W   = 32;
  localparam int unsigned BURST_W = 8;

  localparam logic [CH_W-1:0]    LAST_CH     = CH_W'(N_CH - 1);
  localparam logic [BURST_W-1:0] MAX_BURST_V = BURST_W'(MAX_BURST);

  typedef struct packed {
    logic [3:0]        rsvd;
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] data;
  } out_word_t;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  state_t             state, state_next;
  logic [CH_W-1:0]    grant_ch, grant_next;
  logic [BURST_W-1:0] burst_cnt, burst_next;
  logic [CNT_W-1:0]   word_cnt;
  out_word_t          out_word, out_word_next;
  logic               out_valid, out_valid_next;
  logic               pop_c;

  logic [N_CH-1:0]    elig;
  logic [N_CH-1:0]    grant_sel;
  logic               g_en;
  logic               g_empty;
  logic [DATA_W-1:0]  g_data;
  logic               scan_found;
  logic [CH_W-1:0]    scan_ch;
  int unsigned        scan_dist;
  int unsigned        scan_best;

  assign elig = CH_EN & ~FIFO_EMPTY;

  // Decode the granted channel and mux its enable, empty flag and head word.
  always_comb begin
    grant_sel = '0;
    g_en      = 1'b0;
    g_empty   = 1'b0;
    g_data    = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      grant_sel[i] = (grant_ch == CH_W'(i));
      g_en         = g_en    | (grant_sel[i] & CH_EN[i]);
      g_empty      = g_empty | (grant_sel[i] & FIFO_EMPTY[i]);
      g_data       = g_data  | ({DATA_W{grant_sel[i]}} & FIFO_DATA[DATA_W*i +: DATA_W]);
    end
  end

  // Round-robin scan: distance 0 is the channel after the last grant, the last grant itself is farthest.
  always_comb begin
    scan_found = 1'b0;
    scan_ch    = grant_ch;
    scan_best  = N_CH;
    scan_dist  = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      scan_dist = i + N_CH - 32'(grant_ch) - 32'd1;
      if (scan_dist >= N_CH) begin
        scan_dist = scan_dist - N_CH;
      end
      if (elig[i] && (scan_dist < scan_best)) begin
        scan_best  = scan_dist;
        scan_ch    = CH_W'(i);
        scan_found = 1'b1;
      end
    end
  end

  // Next-state and pop decision.
  always_comb begin
    state_next     = state;
    grant_next     = grant_ch;
    burst_next     = burst_cnt;
    out_word_next  = out_word;
    out_valid_next = out_valid;
    pop_c          = 1'b0;

    case (state)
      ST_IDLE: begin
        if (scan_found) begin
          grant_next = scan_ch;
          burst_next = '0;
          state_next = ST_XFER;
        end
      end
      ST_XFER: begin
        pop_c = g_en & ~g_empty & (~out_valid | OUT_READY) & (burst_cnt < MAX_BURST_V);
        if (pop_c) begin
          out_word_next  = '{rsvd: 4'h0, ch: grant_ch, data: g_data};
          out_valid_next = 1'b1;
          burst_next     = burst_cnt + BURST_W'(1);
        end else if (g_empty || !g_en || (burst_cnt == MAX_BURST_V)) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    // A consumed word with nothing to replace it empties the output register in any state.
    if (OUT_READY && out_valid && !pop_c) begin
      out_valid_next = 1'b0;
    end
  end

  always_comb begin
    FIFO_READ = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      FIFO_READ[i] = pop_c & grant_sel[i];
    end
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state     <= ST_IDLE;
      grant_ch  <= LAST_CH;
      burst_cnt <= '0;
      out_word  <= '0;
      out_valid <= 1'b0;
      word_cnt  <= '0;
    end else begin
      state     <= state_next;
      grant_ch  <= grant_next;
      burst_cnt <= burst_next;
      out_word  <= out_word_next;
      out_valid <= out_valid_next;
      if (pop_c) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
    end
  end

  assign OUT_DATA  = out_word;
  assign OUT_VALID = out_valid;
  assign GRANT_CH  = grant_ch;
  assign BUSY      = (state == ST_XFER);
  assign WORD_CNT  = word_cnt;

endmodule

// File: tb/tb_fei4_rx_arbiter.sv
// Bench for fei4_rx_arbiter: two instances (burst 16 and burst 4) fed by queue-modelled
// FWFT FIFOs; accepted output words are checked against an expected-word scoreboard.
module tb_fei4_rx_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [3:0]  ch_en      [2];
  logic [3:0]  fifo_empty [2];
  logic [95:0] fifo_data  [2];
  logic [3:0]  fifo_read  [2];
  logic [31:0] out_data   [2];
  logic        out_valid  [2];
  logic        out_ready  [2];
  logic [3:0]  grant_ch   [2];
  logic        busy       [2];
  logic [31:0] word_cnt   [2];

  fei4_rx_arbiter #(.N_CH(4), .MAX_BURST(16)) u_dut16 (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .CH_EN(ch_en[0]), .FIFO_EMPTY(fifo_empty[0]),
    .FIFO_DATA(fifo_data[0]), .FIFO_READ(fifo_read[0]), .OUT_DATA(out_data[0]),
    .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .GRANT_CH(grant_ch[0]),
    .BUSY(busy[0]), .WORD_CNT(word_cnt[0]));

  fei4_rx_arbiter #(.N_CH(4), .MAX_BURST(4)) u_dut4 (
    .BUS_CLK(clk), .BUS_RST_N(rst_n), .CH_EN(ch_en[1]), .FIFO_EMPTY(fifo_empty[1]),
    .FIFO_DATA(fifo_data[1]), .FIFO_READ(fifo_read[1]), .OUT_DATA(out_data[1]),
    .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .GRANT_CH(grant_ch[1]),
    .BUSY(busy[1]), .WORD_CNT(word_cnt[1]));

  logic [23:0] fq    [2][4][$];
  logic [31:0] exp_q [2][$];
  int          stamp [$];
  int          acc_n [2];
  int          cyc;
  int          ch2_reads;
  int          errors;
  int          checks;

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  mask;
    logic [15:0] order;
    int          n;
    logic [3:0]  last;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  function automatic void refresh();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        fifo_empty[k][c] = (fq[k][c].size() == 0);
        fifo_data[k][24*c +: 24] = (fq[k][c].size() == 0) ? 24'h0 : fq[k][c][0];
      end
    end
  endfunction

  function automatic void flush(input int k);
    for (int c = 0; c < 4; c++) fq[k][c].delete();
    refresh();
  endfunction

  // One clock: sample pre-edge strobes, let the edge happen, then model FIFO pops and score output.
  task automatic tick();
    logic [3:0]  rd  [2];
    logic        acc [2];
    logic [31:0] od  [2];
    #1;
    for (int k = 0; k < 2; k++) begin
      rd[k]  = fifo_read[k];
      acc[k] = out_valid[k] & out_ready[k];
      od[k]  = out_data[k];
      check("read_onehot", 32'($countones(rd[k]) <= 1), 32'd1);
    end
    if (rd[0][2]) ch2_reads++;
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 4; c++) begin
        if (rd[k][c]) begin
          if (fq[k][c].size() == 0) begin
            errors++;
            checks++;
            $display("FAIL pop_empty: inst %0d popped empty ch %0d", k, c);
          end else begin
            void'(fq[k][c].pop_front());
          end
        end
      end
      if (acc[k]) begin
        acc_n[k]++;
        if (k == 1) stamp.push_back(cyc);
        if (exp_q[k].size() == 0) begin
          errors++;
          checks++;
          $display("FAIL stream_extra: inst %0d got 0x%08h expected no word", k, od[k]);
        end else begin
          check($sformatf("stream%0d", k), od[k], exp_q[k].pop_front());
        end
      end
    end
    refresh();
    @(negedge clk);
  endtask

  task automatic drain(input int k, input int maxc, input string name);
    int n;
    n = 0;
    while ((exp_q[k].size() != 0 || busy[k] || out_valid[k]) && n < maxc) begin
      tick();
      n++;
    end
    check({name, "_drain"}, 32'(exp_q[k].size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t        vt [7];
    int          n;
    int          nx [2];
    int          bch [6];
    int          bn  [6];
    logic [15:0] ord;
    logic [3:0]  ch;

    vt[0] = '{en: 4'hF, mask: 4'b0001, order: 16'h0000, n: 1, last: 4'd0};
    vt[1] = '{en: 4'hF, mask: 4'b1111, order: 16'h0321, n: 4, last: 4'd0};
    vt[2] = '{en: 4'hF, mask: 4'b1001, order: 16'h0003, n: 2, last: 4'd0};
    vt[3] = '{en: 4'h6, mask: 4'b1111, order: 16'h0021, n: 2, last: 4'd2};
    vt[4] = '{en: 4'hF, mask: 4'b0100, order: 16'h0002, n: 1, last: 4'd2};
    vt[5] = '{en: 4'hF, mask: 4'b0011, order: 16'h0010, n: 2, last: 4'd1};
    vt[6] = '{en: 4'h8, mask: 4'b1000, order: 16'h0003, n: 1, last: 4'd3};

    errors = 0; checks = 0; cyc = 0; ch2_reads = 0;
    acc_n[0] = 0; acc_n[1] = 0;
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      ch_en[k] = 4'hF;
      out_ready[k] = 1'b1;
      for (int c = 0; c < 4; c++) begin
        fq[k][c].push_back(24'hABC000 + 24'(c));
        fq[k][c].push_back(24'hABC100 + 24'(c));
      end
    end
    refresh();
    #2 rst_n = 1'b0;

    // Reset with every FIFO non-empty and enabled.
    @(negedge clk);
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check("rst_read",   32'(fifo_read[k]), 32'd0);
      check("rst_valid",  32'(out_valid[k]), 32'd0);
      check("rst_data",   out_data[k], 32'd0);
      check("rst_cnt",    word_cnt[k], 32'd0);
      check("rst_grant",  32'(grant_ch[k]), 32'd3);
      check("rst_busy",   32'(busy[k]), 32'd0);
    end
    flush(0); flush(1);
    ch_en[0] = 4'h0; ch_en[1] = 4'h0;
    rst_n = 1'b1;
    repeat (2) tick();

    // Single channel: ch2 with five words streams on consecutive cycles.
    ch_en[0] = 4'hF;
    for (int i = 1; i <= 5; i++) begin
      fq[0][2].push_back(24'(i));
      exp_q[0].push_back(32'h0200_0000 + 32'(i));
    end
    refresh();
    n = 0;
    while (!out_valid[0] && n < 10) begin tick(); n++; end
    check("t2_latency", 32'(n), 32'd2);
    for (int i = 0; i < 5; i++) begin
      check("t2_valid", 32'(out_valid[0]), 32'd1);
      tick();
    end
    check("t2_valid_end", 32'(out_valid[0]), 32'd0);
    check("t2_busy_end",  32'(busy[0]), 32'd0);
    check("t2_cnt",       word_cnt[0], 32'd5);
    check("t2_grant",     32'(grant_ch[0]), 32'd2);
    check("t2_left",      32'(exp_q[0].size()), 32'd0);

    // Fairness on the burst-4 instance: ch0 and ch1 with ten words each.
    ch_en[1] = 4'hF;
    for (int i = 1; i <= 10; i++) begin
      fq[1][0].push_back(24'h000100 + 24'(i));
      fq[1][1].push_back(24'h000200 + 24'(i));
    end
    bch = '{0, 1, 0, 1, 0, 1};
    bn  = '{4, 4, 4, 4, 2, 2};
    nx  = '{1, 1};
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < bn[b]; j++) begin
        exp_q[1].push_back({4'h0, 4'(bch[b]), 24'(32'h100 * (bch[b] + 1) + nx[bch[b]])});
        nx[bch[b]]++;
      end
    end
    refresh();
    stamp.delete();
    drain(1, 200, "t3");
    check("t3_accepted", 32'(stamp.size()), 32'd20);
    if (stamp.size() == 20) begin
      check("t3_intra_gap",  32'(stamp[1] - stamp[0]), 32'd1);
      check("t3_switch_gap", 32'(stamp[4] - stamp[3]), 32'd3);
    end
    check("t3_grant", 32'(grant_ch[1]), 32'd1);
    check("t3_cnt",   word_cnt[1], 32'd20);

    // Table-driven round-robin scan vectors, one word per loaded channel.
    for (int v = 0; v < 7; v++) begin
      ch_en[1] = vt[v].en;
      for (int c = 0; c < 4; c++) begin
        if (vt[v].mask[c]) fq[1][c].push_back({8'hA5, 8'(v), 8'(c)});
      end
      ord = vt[v].order;
      for (int j = 0; j < vt[v].n; j++) begin
        ch = ord[4*j +: 4];
        exp_q[1].push_back({4'h0, ch, 8'hA5, 8'(v), 4'h0, ch});
      end
      refresh();
      drain(1, 60, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_grant", v), 32'(grant_ch[1]), 32'(vt[v].last));
      flush(1);
    end
    check("vec_cnt", word_cnt[1], 32'd33);

    // Backpressure: stall seven cycles after two words have been accepted.
    for (int i = 1; i <= 8; i++) begin
      fq[0][1].push_back(24'h000A00 + 24'(i));
      exp_q[0].push_back(32'h0100_0A00 + 32'(i));
    end
    refresh();
    acc_n[0] = 0;
    n = 0;
    while (acc_n[0] < 2 && n < 20) begin tick(); n++; end
    out_ready[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      #1;
      check("t4_stall_read",  32'(fifo_read[0]), 32'd0);
      check("t4_stall_data",  out_data[0], 32'h0100_0A03);
      check("t4_stall_valid", 32'(out_valid[0]), 32'd1);
      tick();
    end
    out_ready[0] = 1'b1;
    n = 0;
    while (exp_q[0].size() != 0 && n < 20) begin tick(); n++; end
    check("t4_resume_cycles", 32'(n), 32'd6);
    drain(0, 20, "t4");
    check("t4_cnt", word_cnt[0], 32'd13);

    // Enable mask 1011, then ch0 enable dropped after its third word is accepted.
    ch_en[0] = 4'b1011;
    for (int i = 1; i <= 10; i++) fq[0][0].push_back(24'h000500 + 24'(i));
    for (int i = 1; i <= 3; i++)  fq[0][1].push_back(24'h000600 + 24'(i));
    for (int i = 1; i <= 3; i++)  fq[0][2].push_back(24'h000700 + 24'(i));
    for (int i = 1; i <= 2; i++)  fq[0][3].push_back(24'h000800 + 24'(i));
    for (int i = 1; i <= 2; i++)  exp_q[0].push_back(32'h0300_0800 + 32'(i));
    for (int i = 1; i <= 4; i++)  exp_q[0].push_back(32'h0000_0500 + 32'(i));
    for (int i = 1; i <= 3; i++)  exp_q[0].push_back(32'h0100_0600 + 32'(i));
    refresh();
    ch2_reads = 0;
    acc_n[0] = 0;
    n = 0;
    while (acc_n[0] < 5 && n < 40) begin tick(); n++; end
    ch_en[0] = 4'b1010;
    drain(0, 60, "t5");
    check("t5_ch2_reads", 32'(ch2_reads), 32'd0);
    check("t5_ch2_left",  32'(fq[0][2].size()), 32'd3);
    check("t5_ch0_left",  32'(fq[0][0].size()), 32'd6);
    check("t5_grant",     32'(grant_ch[0]), 32'd1);
    check("t5_cnt",       word_cnt[0], 32'd22);

    // Word counter wrap from a forced preload.
    flush(0);
    force u_dut16.word_cnt = 32'hFFFF_FFFE;
    tick();
    release u_dut16.word_cnt;
    tick();
    check("t6_preload", word_cnt[0], 32'hFFFF_FFFE);
    ch_en[0] = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      fq[0][3].push_back(24'h000900 + 24'(i));
      exp_q[0].push_back(32'h0300_0900 + 32'(i));
    end
    refresh();
    drain(0, 30, "t6");
    check("t6_wrap",  word_cnt[0], 32'h0000_0001);
    check("t6_grant", 32'(grant_ch[0]), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
